// File: rtl/qid_locator_seq_pkg.sv
// Shared widths, encodings and FSM states for the QID locator.
// The macro block stands in for define.v and must be compiled before the other rtl files.
`ifndef QID_LOCATOR_DEFINES
`define QID_LOCATOR_DEFINES
`define OPCODE_BW      4
`define LQADDR_BW      4
`define NUM_LQ         8
`define PP_I           2'b00
`define INVALID_OPCODE 4'hF
`define ST_IDLE        2'd0
`define ST_ACCUM       2'd1
`define ST_OUT         2'd2
`endif

package qid_locator_seq_pkg;
    localparam int OPCODE_BW = `OPCODE_BW;
    localparam int LQADDR_BW = `LQADDR_BW;

    localparam logic [1:0]           PP_I           = `PP_I;
    localparam logic [OPCODE_BW-1:0] INVALID_OPCODE = `INVALID_OPCODE;

    localparam logic [1:0] ST_IDLE  = `ST_IDLE;
    localparam logic [1:0] ST_ACCUM = `ST_ACCUM;
    localparam logic [1:0] ST_OUT   = `ST_OUT;

    // Offset field is at least one bit wide, even with a single chunk.
    function automatic int off_bw(input int num_chunk);
        return (num_chunk > 1) ? $clog2(num_chunk) : 1;
    endfunction
endpackage

// File: rtl/qid_chunk_decode.sv
// Expands one LPP chunk into per-LQ opcode / mreg / Pauli / participation fields.
module qid_chunk_decode
    import qid_locator_seq_pkg::*;
#(
    parameter int CHUNK_LEN = 4
) (
    input  logic [OPCODE_BW-1:0]                 opcode,
    input  logic [LQADDR_BW-1:0]                 mregdst,
    input  logic [2*CHUNK_LEN-1:0]               lpplist,
    output logic [CHUNK_LEN-1:0][OPCODE_BW-1:0]  opcode_lq,
    output logic [CHUNK_LEN-1:0][LQADDR_BW-1:0]  mregdst_lq,
    output logic [CHUNK_LEN-1:0][1:0]            lpp_lq,
    output logic [CHUNK_LEN-1:0]                 lq
);
    for (genvar i = 0; i < CHUNK_LEN; i++) begin : g_lq
        assign lpp_lq[i]     = lpplist[2*i +: 2];
        assign lq[i]         = (lpp_lq[i] != PP_I);
        assign opcode_lq[i]  = lq[i] ? opcode  : INVALID_OPCODE;
        assign mregdst_lq[i] = lq[i] ? mregdst : '0;
    end
endmodule

// File: rtl/qid_locator_seq.sv
// Assembles chunked LPP lists of one instruction into a per-LQ map and
// holds it until the consumer takes it.
module qid_locator_seq
    import qid_locator_seq_pkg::*;
#(
    parameter int  NUM_LQ    = `NUM_LQ,
    parameter int  CHUNK_LEN = 4,
    localparam int NUM_CHUNK = NUM_LQ / CHUNK_LEN,
    localparam int OFF_BW    = off_bw(NUM_CHUNK)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OPCODE_BW-1:0]        in_opcode,
    input  logic [LQADDR_BW-1:0]        in_mregdst,
    input  logic [OFF_BW-1:0]           in_offset,
    input  logic                        in_last,
    input  logic [2*CHUNK_LEN-1:0]      in_lpplist,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LQ*OPCODE_BW-1:0] opcode_loc,
    output logic [NUM_LQ*LQADDR_BW-1:0] mregdst_loc,
    output logic [NUM_LQ*2-1:0]         lpplist_loc,
    output logic [NUM_LQ-1:0]           lqlist_loc,
    output logic                        err
);
    logic [1:0]           state, state_nxt;
    logic [NUM_CHUNK-1:0] written;
    logic [OPCODE_BW-1:0] op_lat;

    logic [NUM_LQ-1:0][OPCODE_BW-1:0] opcode_map;
    logic [NUM_LQ-1:0][LQADDR_BW-1:0] mregdst_map;
    logic [NUM_LQ-1:0][1:0]           lpp_map;
    logic [NUM_LQ-1:0]                lq_map;

    logic [CHUNK_LEN-1:0][OPCODE_BW-1:0] opcode_lq;
    logic [CHUNK_LEN-1:0][LQADDR_BW-1:0] mregdst_lq;
    logic [CHUNK_LEN-1:0][1:0]           lpp_lq;
    logic [CHUNK_LEN-1:0]                lq;

    logic accept, drain, offset_ok, already, mismatch, reject, wr_en;

    qid_chunk_decode #(.CHUNK_LEN(CHUNK_LEN)) u_decode (
        .opcode     (in_opcode),
        .mregdst    (in_mregdst),
        .lpplist    (in_lpplist),
        .opcode_lq  (opcode_lq),
        .mregdst_lq (mregdst_lq),
        .lpp_lq     (lpp_lq),
        .lq         (lq)
    );

    assign in_ready  = (state != ST_OUT);
    assign out_valid = (state == ST_OUT);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Extra MSB keeps the range check meaningful when NUM_CHUNK is a power of two.
    assign offset_ok = ({1'b0, in_offset} < (OFF_BW+1)'(NUM_CHUNK));
    assign already   = offset_ok && written[in_offset];
    assign mismatch  = (state == ST_ACCUM) && (in_opcode != op_lat);
    assign reject    = !offset_ok || already || mismatch;
    assign wr_en     = accept && !reject;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ACCUM: if (accept) state_nxt = in_last ? ST_OUT : ST_ACCUM;
            ST_OUT:            if (out_ready) state_nxt = ST_IDLE;
            default:           state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            written <= '0;
            op_lat  <= INVALID_OPCODE;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= accept && reject;
            if (drain) begin
                written <= '0;
                op_lat  <= INVALID_OPCODE;
            end else begin
                if (accept && state == ST_IDLE) op_lat <= in_opcode;
                if (wr_en) written[in_offset] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < NUM_LQ; q++) begin
                opcode_map[q]  <= INVALID_OPCODE;
                mregdst_map[q] <= '0;
                lpp_map[q]     <= PP_I;
                lq_map[q]      <= 1'b0;
            end
        end else if (drain) begin
            for (int q = 0; q < NUM_LQ; q++) begin
                opcode_map[q]  <= INVALID_OPCODE;
                mregdst_map[q] <= '0;
                lpp_map[q]     <= PP_I;
                lq_map[q]      <= 1'b0;
            end
        end else if (wr_en) begin
            for (int c = 0; c < NUM_CHUNK; c++) begin
                if (in_offset == OFF_BW'(c)) begin
                    for (int i = 0; i < CHUNK_LEN; i++) begin
                        opcode_map[c*CHUNK_LEN+i]  <= opcode_lq[i];
                        mregdst_map[c*CHUNK_LEN+i] <= mregdst_lq[i];
                        lpp_map[c*CHUNK_LEN+i]     <= lpp_lq[i];
                        lq_map[c*CHUNK_LEN+i]      <= lq[i];
                    end
                end
            end
        end
    end

    assign opcode_loc  = opcode_map;
    assign mregdst_loc = mregdst_map;
    assign lpplist_loc = lpp_map;
    assign lqlist_loc  = lq_map;
endmodule

// File: tb/tb_qid_locator_seq.sv
// Directed bench: 8 LQ x 4-entry chunks, plus an 8 LQ x 8-entry instance
// whose 1-bit offset can express an out-of-range chunk.
module tb_qid_locator_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main DUT: NUM_LQ=8, CHUNK_LEN=4
    logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [3:0]  in_opcode = '0, in_mregdst = '0;
    logic        in_offset = 1'b0;
    logic [7:0]  in_lpplist = '0;
    logic        out_valid, out_ready = 1'b0, err;
    logic [31:0] opcode_loc, mregdst_loc;
    logic [15:0] lpplist_loc;
    logic [7:0]  lqlist_loc;

    // single-chunk DUT: NUM_LQ=8, CHUNK_LEN=8
    logic        b_in_valid = 1'b0, b_in_ready, b_in_last = 1'b0;
    logic [3:0]  b_in_opcode = '0, b_in_mregdst = '0;
    logic        b_in_offset = 1'b0;
    logic [15:0] b_in_lpplist = '0;
    logic        b_out_valid, b_out_ready = 1'b0, b_err;
    logic [31:0] b_opcode_loc, b_mregdst_loc;
    logic [15:0] b_lpplist_loc;
    logic [7:0]  b_lqlist_loc;

    int tests = 0;
    int fails = 0;

    qid_locator_seq #(.NUM_LQ(8), .CHUNK_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_mregdst(in_mregdst), .in_offset(in_offset), .in_last(in_last),
        .in_lpplist(in_lpplist), .out_valid(out_valid), .out_ready(out_ready),
        .opcode_loc(opcode_loc), .mregdst_loc(mregdst_loc),
        .lpplist_loc(lpplist_loc), .lqlist_loc(lqlist_loc), .err(err)
    );

    qid_locator_seq #(.NUM_LQ(8), .CHUNK_LEN(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_opcode(b_in_opcode),
        .in_mregdst(b_in_mregdst), .in_offset(b_in_offset), .in_last(b_in_last),
        .in_lpplist(b_in_lpplist), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .opcode_loc(b_opcode_loc), .mregdst_loc(b_mregdst_loc),
        .lpplist_loc(b_lpplist_loc), .lqlist_loc(b_lqlist_loc), .err(b_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_maps(input string tag, input logic [31:0] op, input logic [31:0] mr,
                            input logic [15:0] lpp, input logic [7:0] lq);
        chk({tag, ".opcode"},  64'(opcode_loc),  64'(op));
        chk({tag, ".mregdst"}, 64'(mregdst_loc), 64'(mr));
        chk({tag, ".lpplist"}, 64'(lpplist_loc), 64'(lpp));
        chk({tag, ".lqlist"},  64'(lqlist_loc),  64'(lq));
    endtask

    // drive one chunk for a single cycle; outputs are sampled 1 time unit after the edge
    task automatic send(input logic off, input logic last, input logic [3:0] op,
                        input logic [3:0] mr, input logic [7:0] lpp);
        in_valid = 1'b1; in_offset = off; in_last = last;
        in_opcode = op; in_mregdst = mr; in_lpplist = lpp;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.err", 64'(err), 64'd0);
        chk_maps("rst", 32'hFFFF_FFFF, 32'h0, 16'h0, 8'h00);
        rst_n = 1'b1;
        step();

        // single chunk: entries {Z,I,X,I} at offset 1 -> LQ4=Z, LQ6=X
        send(1'b1, 1'b1, 4'd5, 4'd3, 8'h12);
        chk("single.out_valid", 64'(out_valid), 64'd1);
        chk("single.in_ready", 64'(in_ready), 64'd0);
        chk_maps("single", 32'hF5F5_FFFF, 32'h0303_0000, 16'h1200, 8'h50);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single.drained", 64'(out_valid), 64'd0);

        // two chunks, all X
        send(1'b0, 1'b0, 4'd2, 4'd1, 8'h55);
        chk("two.first_not_valid", 64'(out_valid), 64'd0);
        chk("two.in_ready", 64'(in_ready), 64'd1);
        send(1'b1, 1'b1, 4'd2, 4'd1, 8'h55);
        chk("two.out_valid", 64'(out_valid), 64'd1);
        chk_maps("two", 32'h2222_2222, 32'h1111_1111, 16'h5555, 8'hFF);

        // backpressure with a pending chunk on the input
        in_valid = 1'b1; in_offset = 1'b0; in_last = 1'b1;
        in_opcode = 4'd9; in_mregdst = 4'd7; in_lpplist = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp.in_ready", 64'(in_ready), 64'd0);
            chk("bp.out_valid", 64'(out_valid), 64'd1);
            chk("bp.lqlist", 64'(lqlist_loc), 64'hFF);
            chk("bp.opcode", 64'(opcode_loc), 64'h2222_2222);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp.out_valid_after", 64'(out_valid), 64'd0);
        chk("bp.in_ready_after", 64'(in_ready), 64'd1);
        chk_maps("bp.cleared", 32'hFFFF_FFFF, 32'h0, 16'h0, 8'h00);

        // errors: repeated offset, then opcode mismatch on the last chunk
        send(1'b0, 1'b0, 4'd7, 4'd2, 8'h55);
        chk("err.none", 64'(err), 64'd0);
        send(1'b0, 1'b0, 4'd7, 4'd4, 8'hAA);
        chk("err.repeat", 64'(err), 64'd1);
        chk_maps("err.repeat", 32'hFFFF_7777, 32'h0000_2222, 16'h0055, 8'h0F);
        step();
        chk("err.one_cycle", 64'(err), 64'd0);
        send(1'b1, 1'b1, 4'd9, 4'd4, 8'h55);
        chk("err.mismatch", 64'(err), 64'd1);
        chk("err.last_honoured", 64'(out_valid), 64'd1);
        chk_maps("err.mismatch", 32'hFFFF_7777, 32'h0000_2222, 16'h0055, 8'h0F);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // out-of-range offset on the single-chunk instance
        b_in_valid = 1'b1; b_in_offset = 1'b1; b_in_last = 1'b1;
        b_in_opcode = 4'd6; b_in_mregdst = 4'd5; b_in_lpplist = 16'h5555;
        step();
        b_in_valid = 1'b0;
        chk("oor.err", 64'(b_err), 64'd1);
        chk("oor.out_valid", 64'(b_out_valid), 64'd1);
        chk("oor.lqlist", 64'(b_lqlist_loc), 64'h00);
        chk("oor.opcode", 64'(b_opcode_loc), 64'hFFFF_FFFF);
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;

        // reset mid-ACCUM
        send(1'b0, 1'b0, 4'd3, 4'd6, 8'h55);
        chk("mid.lqlist_before", 64'(lqlist_loc), 64'h0F);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.out_valid", 64'(out_valid), 64'd0);
        chk("mid.in_ready", 64'(in_ready), 64'd1);
        chk("mid.err", 64'(err), 64'd0);
        chk_maps("mid", 32'hFFFF_FFFF, 32'h0, 16'h0, 8'h00);
        step();
        rst_n = 1'b1;
        step();
        // stale opcode 3 must not be latched: a single opcode-5 chunk assembles cleanly
        send(1'b1, 1'b1, 4'd5, 4'd3, 8'h12);
        chk("post.err", 64'(err), 64'd0);
        chk("post.out_valid", 64'(out_valid), 64'd1);
        chk_maps("post", 32'hF5F5_FFFF, 32'h0303_0000, 16'h1200, 8'h50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end by 100000");
        $fatal(1);
    end
endmodule
